data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised, word-organised data memory with a valid/ready request port and a registered response port, for the load/store stage of the core. Supports lb/lbu/lh/lhu/lw/sb/sh/sw via funct3 with per-byte write enables. Unlike the single-cycle byte array it replaces, it drives a synchronous exception line for bad accesses. It also either splits misaligned halfword/word accesses into two word accesses or rejects them, selected by a parameter.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; the valid byte range is 0 .. 4*DEPTH_WORDS-1.
MISALIGN_SPLIT, 1, 1 = misaligned accesses are split into two word accesses; 0 = misaligned accesses are reported as errors.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I size/sign encoding.
req_addr  input  32  byte address.
req_wdata  input  32  store data; the low bytes are used according to size.
rsp_valid  output  1  one-cycle pulse: access complete.
rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
rsp_err  output  1  valid only with rsp_valid: access rejected (the synchronous exception line).

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0. req_ready=1 once reset is released. Memory contents are not affected by reset; they initialise to all zero at elaboration.
- Storage is DEPTH_WORDS x 32 bits. Word index = addr[31:2]; byte offset = addr[1:0]. Byte lane k is bits [8k+7:8k], little-endian.
- A handshake occurs when req_valid && req_ready. req_ready = (state==IDLE). rsp has no backpressure.
- Decode happens in the handshake cycle:
  - size = funct3[1:0], with 00=1, 01=2, 10=4 bytes.
  - illegal funct3 = 011, 110, 111; also 1xx when req_we=1.
  - misaligned = (size 2 && addr[0]) or (size 4 && addr[1:0]!=0).
  - out-of-range = the word index of the first byte or of the last byte (addr+size-1, 32-bit wrap) is >= DEPTH_WORDS.
- An error (illegal, out-of-range, or misaligned with MISALIGN_SPLIT=0) performs no memory write. The next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0. State stays IDLE.
- Aligned or single-word access: the write applies at the handshake edge using byte enables shifted by the offset. The read is synchronous, with the word registered at the same edge. The next cycle gives rsp_valid=1, rsp_err=0. Latency is 1 cycle; back-to-back requests are accepted every cycle.
- Misaligned spanning two words, MISALIGN_SPLIT=1: the handshake edge accesses word W (bytes offset..3) and goes to state SECOND. In SECOND (req_ready=0), word W+1 is accessed (the remaining low bytes). The next cycle gives rsp_valid=1 and the state returns to IDLE. Latency is 2 cycles and the next request is accepted in the rsp_valid cycle.
- Loads read back the bytes written by the immediately preceding store (no stale read). Within a single-cycle request, read-during-write of the same word returns the new data.
- rsp_rdata extension:
  - lb/lh: sign-extend from bit 7/15 of the assembled value.
  - lbu/lhu: zero-extend.
  - lw: all 32 bits.
  - stores: 0.
- rsp_rdata/rsp_err hold their last value when rsp_valid=0.
- If reset is asserted in SECOND, the state goes to IDLE with no response. The word-W half of a split store is kept and the word-W+1 half is not written.
- The last-byte out-of-range check covers the wrap at 0xFFFFFFFF and is applied before any part of a split is performed.

Test Plan:
1. After reset: sw 0x80000001 @0x10, then lb @0x10 -> 0x00000001; lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080. Each rsp_valid arrives 1 cycle after its handshake; back-to-back requests see req_ready=1 throughout.
2. sh 0xBEEF @0x22, then lw @0x20 -> 0xBEEF0000; lh @0x22 -> 0xFFFFBEEF; lhu @0x22 -> 0x0000BEEF.
3. MISALIGN_SPLIT=1: sw 0x11223344 @0x3E -> req_ready=0 for 1 cycle and rsp_valid 2 cycles after the handshake. Then lw @0x3C -> 0x33440000, lw @0x40 -> 0x00001122, lw @0x3E -> 0x11223344.
4. MISALIGN_SPLIT=0: lw @0x41 -> rsp_err=1, rsp_rdata=0, latency 1. sh @0x41 -> rsp_err=1 and memory is unchanged (lw @0x40 returns its previous value).
5. Bad accesses: funct3=011 load -> err; funct3=100 store -> err, no write; lw @4*DEPTH_WORDS -> err; sw @0xFFFFFFFE -> err, no write.
6. Assert reset_n=0 in SECOND of a split sw 0xAABBCCDD @0x5D -> no rsp_valid. After release, lw @0x5C -> 0xBBCCDD00 and lw @0x60 -> 0x00000000.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory for the load/store stage.
// Takes one request per cycle on a valid/ready port and returns a registered
// response one cycle later. Byte, halfword and word loads and stores are
// selected by funct3. Illegal, out-of-range and (optionally) misaligned
// accesses are answered with rsp_err. Accesses that straddle two words are
// either split into two back-to-back word accesses or rejected, selected by
// MISALIGN_SPLIT.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS    = 4096,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {IDLE, SECOND} state_t;

    // Storage starts at all-zero and is deliberately left out of the reset.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    state_t        state_reg;
    logic [1:0]    off_reg;
    logic [2:0]    f3_reg;
    logic          we_reg;
    logic [AW-1:0] idx_hi_reg;
    logic [3:0]    be_hi_reg;
    logic [31:0]   wdata_hi_reg;
    logic [31:0]   lo_word_reg;

    logic          hs;
    logic [1:0]    off;
    logic [2:0]    size_m1;
    logic [3:0]    size_mask;
    logic [2:0]    end_off;
    logic [31:0]   last_addr;
    logic          illegal;
    logic          out_of_range;
    logic          misaligned;
    logic          req_err;
    logic          do_split;
    logic [7:0]    be_full;
    logic [63:0]   data_full;
    logic [AW-1:0] mem_idx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rd;
    logic [31:0]   merged;
    logic [63:0]   split_pair;

    assign req_ready = (state_reg == IDLE);
    assign hs        = req_valid && req_ready && reset_n;
    assign off       = req_addr[1:0];

    // Sign- or zero-extend the lane-aligned load value according to funct3.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'b0, v[7:0]};
            3'b101:  extend = {16'b0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Request decode: access size, legality, range and alignment.
    always_comb begin
        size_m1   = 3'd0;
        size_mask = 4'b0001;
        case (req_funct3[1:0])
            2'b01: begin size_m1 = 3'd1; size_mask = 4'b0011; end
            2'b10: begin size_m1 = 3'd3; size_mask = 4'b1111; end
            default: ;
        endcase
        illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        // The last byte may wrap past 0xFFFFFFFF; its word index is then
        // small, but the first-byte check still rejects the access.
        last_addr    = req_addr + {29'b0, size_m1};
        out_of_range = ({2'b0, req_addr[31:2]}  >= 32'(DEPTH_WORDS)) ||
                       ({2'b0, last_addr[31:2]} >= 32'(DEPTH_WORDS));
        misaligned   = ((size_m1 == 3'd1) && req_addr[0]) ||
                       ((size_m1 == 3'd3) && (off != 2'b00));
        req_err      = illegal || out_of_range || (misaligned && !MISALIGN_SPLIT);
        // Crossing into the next word happens when offset + size exceeds 4.
        end_off      = {1'b0, off} + size_m1;
        do_split     = !req_err && end_off[2];
        be_full      = {4'b0, size_mask} << off;
        data_full    = {32'b0, req_wdata} << {off, 3'b000};
    end

    // Single memory port: the second half of a split owns it in SECOND,
    // otherwise it serves the incoming request.
    always_comb begin
        mem_idx   = req_addr[AW+1:2];
        mem_be    = 4'b0000;
        mem_wdata = data_full[31:0];
        if (state_reg == SECOND) begin
            mem_idx   = idx_hi_reg;
            mem_wdata = wdata_hi_reg;
            mem_be    = we_reg ? be_hi_reg : 4'b0000;
        end else if (hs && !req_err && req_we) begin
            mem_be    = be_full[3:0];
        end
    end

    assign mem_rd = mem[mem_idx];

    // Read-during-write of the same word returns the freshly written lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = mem_be[gi] ? mem_wdata[8*gi +: 8] : mem_rd[8*gi +: 8];
        end
    endgenerate

    assign split_pair = {merged, lo_word_reg} >> {off_reg, 3'b000};

    // Byte-enabled memory write; no reset so contents survive reset_n.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'b0;
            off_reg      <= 2'b0;
            f3_reg       <= 3'b0;
            we_reg       <= 1'b0;
            idx_hi_reg   <= '0;
            be_hi_reg    <= 4'b0;
            wdata_hi_reg <= 32'b0;
            lo_word_reg  <= 32'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hs) begin
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'b0;
                        end else if (do_split) begin
                            state_reg    <= SECOND;
                            off_reg      <= off;
                            f3_reg       <= req_funct3;
                            we_reg       <= req_we;
                            idx_hi_reg   <= mem_idx + AW'(1);
                            be_hi_reg    <= be_full[7:4];
                            wdata_hi_reg <= data_full[63:32];
                            lo_word_reg  <= merged;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= req_we ? 32'b0 :
                                         extend(req_funct3, merged >> {off, 3'b000});
                        end
                    end
                end
                SECOND: begin
                    state_reg <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_reg ? 32'b0 : extend(f3_reg, split_pair[31:0]);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance splits misaligned accesses,
// a second instance rejects them. Vectors come from a table; back-to-back,
// split-handshake and reset-during-split cases are hand-written sequences.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;

    logic        clock;
    logic        reset_n;
    logic        a_valid, a_ready, a_we, a_rsp_valid, a_err;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_err;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .MISALIGN_SPLIT(1'b1)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .MISALIGN_SPLIT(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          sel;       // 0 = splitting instance, 1 = rejecting instance
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        rdy = sel ? b_ready : a_ready;
    endfunction
    function automatic logic rv(input bit sel);
        rv = sel ? b_rsp_valid : a_rsp_valid;
    endfunction
    function automatic logic [31:0] rd(input bit sel);
        rd = sel ? b_rdata : a_rdata;
    endfunction
    function automatic logic er(input bit sel);
        er = sel ? b_err : a_err;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_valid = v; b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wdata;
        end else begin
            a_valid = v; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Issue one request and wait (bounded) for its response.
    task automatic apply(input vec_t v, input string nm);
        int   lat;
        logic seen;
        @(negedge clock);
        drive(v.sel, 1'b1, v.we, v.f3, v.addr, v.wdata);
        check({nm, " ready"}, 32'(rdy(v.sel)), 32'd1);
        @(posedge clock);
        @(negedge clock);
        drive(v.sel, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        lat  = 1;
        seen = rv(v.sel);
        if (v.exp_lat == 2 && !seen) check({nm, " busy"}, 32'(rdy(v.sel)), 32'd0);
        while (!seen && lat < 6) begin
            @(negedge clock);
            lat++;
            seen = rv(v.sel);
        end
        check({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({nm, " rdata"}, rd(v.sel), v.exp_rdata);
        check({nm, " err"}, 32'(er(v.sel)), 32'(v.exp_err));
        $display("%s: we=%0b f3=%03b addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                 nm, v.we, v.f3, v.addr, rd(v.sel), er(v.sel), lat);
    endtask

    vec_t vecs[$];
    vec_t post[$];

    initial begin
        // sel, we, f3, addr, wdata, exp_rdata, exp_err, exp_lat
        vecs.push_back('{0, 1, 3'b010, 32'h10, 32'h80000001, 32'h0, 0, 1});
        vecs.push_back('{0, 0, 3'b000, 32'h10, 32'h0, 32'h00000001, 0, 1});
        vecs.push_back('{0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1});
        vecs.push_back('{0, 0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 1});
        vecs.push_back('{0, 1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 0, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEF0000, 0, 1});
        vecs.push_back('{0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 0, 1});
        vecs.push_back('{0, 0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 0, 1});
        vecs.push_back('{0, 1, 3'b010, 32'h3E, 32'h11223344, 32'h0, 0, 2});
        vecs.push_back('{0, 0, 3'b010, 32'h3C, 32'h0, 32'h33440000, 0, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h40, 32'h0, 32'h00001122, 0, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h3E, 32'h0, 32'h11223344, 0, 2});
        vecs.push_back('{0, 0, 3'b001, 32'h3F, 32'h0, 32'h00002233, 0, 2});
        vecs.push_back('{0, 0, 3'b001, 32'h3D, 32'h0, 32'h00004400, 0, 1});
        vecs.push_back('{0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1});
        vecs.push_back('{0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1});
        vecs.push_back('{0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h10, 32'h0, 32'h80000001, 0, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 1});
        vecs.push_back('{0, 1, 3'b010, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0, 1, 1});
        vecs.push_back('{0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 1});
        vecs.push_back('{0, 0, 3'b010, 32'hFFC, 32'h0, 32'h0, 0, 1});
        vecs.push_back('{0, 0, 3'b001, 32'hFFF, 32'h0, 32'h0, 1, 1});
        vecs.push_back('{1, 1, 3'b010, 32'h40, 32'h12345678, 32'h0, 0, 1});
        vecs.push_back('{1, 0, 3'b010, 32'h41, 32'h0, 32'h0, 1, 1});
        vecs.push_back('{1, 1, 3'b001, 32'h41, 32'h0000FFFF, 32'h0, 1, 1});
        vecs.push_back('{1, 0, 3'b010, 32'h40, 32'h0, 32'h12345678, 0, 1});
        vecs.push_back('{1, 0, 3'b101, 32'h42, 32'h0, 32'h00001234, 0, 1});
        post.push_back('{0, 0, 3'b010, 32'h5C, 32'h0, 32'hBBCCDD00, 0, 1});
        post.push_back('{0, 0, 3'b010, 32'h60, 32'h0, 32'h00000000, 0, 1});

        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset a rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset a rsp_err", 32'(a_err), 32'd0);
        check("reset a rsp_rdata", a_rdata, 32'd0);
        check("reset a ready", 32'(a_ready), 32'd1);
        check("reset b rsp_valid", 32'(b_rsp_valid), 32'd0);
        $display("reset: a_valid=%0b a_rdata=0x%08h a_ready=%0b", a_rsp_valid, a_rdata, a_ready);

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Back-to-back loads: second request presented in the first response cycle.
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        @(posedge clock);
        @(negedge clock);
        check("b2b rsp1 valid", 32'(a_rsp_valid), 32'd1);
        check("b2b rsp1 rdata", a_rdata, 32'h00000001);
        check("b2b ready", 32'(a_ready), 32'd1);
        $display("b2b1: lb 0x10 rdata=0x%08h", a_rdata);
        drive(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        check("b2b rsp2 valid", 32'(a_rsp_valid), 32'd1);
        check("b2b rsp2 rdata", a_rdata, 32'hFFFFFF80);
        $display("b2b2: lb 0x13 rdata=0x%08h", a_rdata);
        @(negedge clock);
        check("hold valid", 32'(a_rsp_valid), 32'd0);
        check("hold rdata", a_rdata, 32'hFFFFFF80);

        // Reset during the second half of a split store.
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h5D, 32'hAABBCCDD);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        check("split busy", 32'(a_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst ready", 32'(a_ready), 32'd1);
        check("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("rst no rsp", 32'(a_rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("rst after valid", 32'(a_rsp_valid), 32'd0);
        check("rst after rdata", a_rdata, 32'd0);
        $display("split reset: released, rsp_valid=%0b", a_rsp_valid);
        foreach (post[i]) apply(post[i], $sformatf("p%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
